noc_packet_receiver: RTL and testbench

Ejection-side network interface for one NoC node: it is the consuming end of a node's `NodeX_data_out` / `NodeX_valid_out` / `NodeX_ready_out` flit stream.
- Accepts fixed-length packets one flit per cycle and reassembles them into a two-slot packet buffer.
- Presents each complete packet to the local core as one wide word with a valid/ready handshake.
- Replaces the free-running always-ready sink, so local back-pressure propagates into the network.

---
 rtl/noc_packet_receiver.sv | 113 +++++++++++
 tb/tb_noc_packet_receiver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_receiver.sv
// NoC ejection interface: reassembles fixed-length flit packets into a two-slot buffer
// and hands each complete packet to the core. Optional build macro: NOC_RX_DEST_CHECK_EN.
module noc_packet_receiver #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_FLITS  = 6,
    parameter int ID_WIDTH   = 4,
    parameter int NODE_ID    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          valid_in,
    output logic                          ready_in,
    output logic [PKT_FLITS*DATA_WIDTH-1:0] pkt_data,
    output logic [ID_WIDTH-1:0]           pkt_src,
    output logic                          pkt_valid,
    input  logic                          pkt_ready,
    output logic [7:0]                    drop_count
);

    // state      | meaning
    // ST_IDLE    | waiting for a head flit; needs a free slot at wr_slot
    // ST_COLLECT | slot allocated, storing body/tail flits at flit_cnt

    localparam int PKT_W = PKT_FLITS * DATA_WIDTH;
    localparam int CNT_W = $clog2(PKT_FLITS);

    if (PKT_FLITS < 2) begin : g_bad_len
        $error("noc_packet_receiver: PKT_FLITS must be at least 2");
    end
    if (NODE_ID < 0 || NODE_ID >= (1 << ID_WIDTH)) begin : g_bad_id
        $error("noc_packet_receiver: NODE_ID does not fit in ID_WIDTH");
    end

    typedef enum logic {ST_IDLE, ST_COLLECT} rx_state_t;

    rx_state_t        state_q, state_d;
    logic [PKT_W-1:0] slot_data [2];
    logic [1:0]       slot_full;
    logic             wr_slot, rd_slot;
    logic [CNT_W-1:0] flit_cnt;
    logic             flit_xfer, tail_xfer, pop, keep_pkt;

    assign ready_in  = rst && ((state_q == ST_COLLECT) || !slot_full[wr_slot]);
    assign flit_xfer = valid_in && ready_in;
    assign tail_xfer = flit_xfer && (state_q == ST_COLLECT)
                       && (flit_cnt == CNT_W'(PKT_FLITS - 1));
    assign pkt_valid = slot_full[rd_slot];
    assign pop       = pkt_valid && pkt_ready;
    assign pkt_data  = slot_data[rd_slot];
    assign pkt_src   = pkt_data[2*ID_WIDTH-1:ID_WIDTH];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (flit_xfer) state_d = ST_COLLECT;
            ST_COLLECT: if (tail_xfer) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            slot_full    <= '0;
            wr_slot      <= 1'b0;
            rd_slot      <= 1'b0;
            flit_cnt     <= '0;
            slot_data[0] <= '0;
            slot_data[1] <= '0;
        end else begin
            state_q <= state_d;
            if (flit_xfer) begin
                slot_data[wr_slot][int'(flit_cnt)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
                flit_cnt <= tail_xfer ? '0 : flit_cnt + 1'b1;
            end
            // pop and completion always address different slots, so both may land together
            if (pop) begin
                slot_full[rd_slot] <= 1'b0;
                rd_slot            <= ~rd_slot;
            end
            if (tail_xfer && keep_pkt) begin
                slot_full[wr_slot] <= 1'b1;
                wr_slot            <= ~wr_slot;
            end
        end
    end

`ifdef NOC_RX_DEST_CHECK_EN
    logic       dest_bad_q;
    logic [7:0] drop_q;

    // misrouted packets are still drained flit-by-flit; the slot is simply reused
    always_ff @(posedge clk) begin
        if (!rst) begin
            dest_bad_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (flit_xfer && (state_q == ST_IDLE))
                dest_bad_q <= (data_in[ID_WIDTH-1:0] != ID_WIDTH'(NODE_ID));
            if (tail_xfer && dest_bad_q && (drop_q != 8'hFF))
                drop_q <= drop_q + 8'd1;
        end
    end

    assign keep_pkt   = !dest_bad_q;
    assign drop_count = drop_q;
`else
    assign keep_pkt   = 1'b1;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_noc_packet_receiver.sv
// Directed bench for noc_packet_receiver: packet-queue model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_noc_packet_receiver;
    localparam int DW = 32;
    localparam int PF = 6;
    localparam int IW = 4;
    localparam int PW = PF * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic [PW-1:0] pkt_data;
    logic [IW-1:0] pkt_src;
    logic          pkt_valid;
    logic          pkt_ready = 1'b0;
    logic [7:0]    drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    noc_packet_receiver #(.DATA_WIDTH(DW), .PKT_FLITS(PF), .ID_WIDTH(IW), .NODE_ID(0)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
        .pkt_data(pkt_data), .pkt_src(pkt_src), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: ordered queue of complete packets plus the partially received one
    logic [PW-1:0] mq[$];
    logic [PW-1:0] part = '0;
    int            pcnt = 0;
    int            m_drops = 0;

    function automatic bit m_ready();
        return rst && (pcnt != 0 || mq.size() < 2);
    endfunction

    function automatic bit dest_ok(input logic [PW-1:0] p);
`ifdef NOC_RX_DEST_CHECK_EN
        logic [IW-1:0] d;
        d = p[IW-1:0];
        return d == '0;
`else
        return p[0] | 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        bit acc, pp;
        if (!rst) begin
            mq.delete();
            pcnt = 0;
            part = '0;
            m_drops = 0;
        end else begin
            acc = valid_in && m_ready();
            pp  = (mq.size() > 0) && pkt_ready;
            if (pp) void'(mq.pop_front());
            if (acc) begin
                part[pcnt*DW +: DW] = data_in;
                pcnt++;
                if (pcnt == PF) begin
                    if (dest_ok(part)) mq.push_back(part);
                    else if (m_drops < 255) m_drops++;
                    pcnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [PW-1:0] head;
        logic [IW-1:0] src;
        check("ready_in", PW'(ready_in), PW'(m_ready()));
        check("pkt_valid", PW'(pkt_valid), PW'(mq.size() > 0));
        if (mq.size() > 0) begin
            head = mq[0];
            src  = head[2*IW-1:IW];
            check("pkt_data", pkt_data, head);
            check("pkt_src", PW'(pkt_src), PW'(src));
        end
        check("drop_count", PW'(drop_count), PW'(m_drops));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, output int cyc);
        bit r;
        r = 1'b0;
        cyc = 0;
        valid_in = 1'b1;
        data_in  = d;
        while (!r && cyc < 100) begin
            @(negedge clk);
            r = ready_in;
            tick();
            cyc++;
        end
        if (!r) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: flit %h not accepted within %0d cycles", d, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pf(input int src, input int f);
        logic [3:0] s;
        s = 4'(src);
        if (f == 0) return {24'h0, s, 4'h0};
        return 32'hA000_0000 | (32'(src) << 8) | 32'(f);
    endfunction

    task automatic send_flits(input int src, input int first, input int last);
        int c;
        for (int f = first; f <= last; f++) send(pf(src, f), c);
    endtask

    initial begin
        int c, tot;
        logic [DW-1:0] t1 [6];
        t1[0] = 32'h10; t1[1] = 32'h11; t1[2] = 32'h22;
        t1[3] = 32'h33; t1[4] = 32'h44; t1[5] = 32'h55;

        // reset
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready", PW'(ready_in), PW'(0));
        check("rst_valid", PW'(pkt_valid), PW'(0));
        check("rst_data", pkt_data, PW'(0));
        check("rst_drop", PW'(drop_count), PW'(0));
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", PW'(ready_in), PW'(1));
        tick();

        // single packet, core always ready
        pkt_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(t1[i], c);
        valid_in = 1'b0;
        @(negedge clk);
        check("t1_valid", PW'(pkt_valid), PW'(1));
        check("t1_src", PW'(pkt_src), PW'(1));
        check("t1_flit0", PW'(pkt_data[31:0]), PW'(32'h10));
        check("t1_flit5", PW'(pkt_data[191:160]), PW'(32'h55));
        tick();
        @(negedge clk);
        check("t1_pulse_end", PW'(pkt_valid), PW'(0));
        tick();
        pkt_ready = 1'b0;

        // three back-to-back packets against a stalled core
        tot = 0;
        for (int p = 0; p < 2; p++)
            for (int f = 0; f < 6; f++) begin
                send(pf(p + 2, f), c);
                tot += c;
            end
        check("no_bubble_cycles", PW'(tot), PW'(12));
        valid_in = 1'b1;
        data_in  = pf(4, 0);
        @(negedge clk);
        check("head3_blocked", PW'(ready_in), PW'(0));
        check("hold_src_pkt1", PW'(pkt_src), PW'(2));
        tick();
        pkt_ready = 1'b1;
        @(negedge clk);
        check("blocked_until_pop", PW'(ready_in), PW'(0));
        tick();
        pkt_ready = 1'b0;
        @(negedge clk);
        check("ready_after_pop", PW'(ready_in), PW'(1));
        check("next_src_pkt2", PW'(pkt_src), PW'(3));
        tick();
        send_flits(4, 1, 5);
        valid_in = 1'b0;
        pkt_ready = 1'b1;
        @(negedge clk);
        check("order_pkt2", PW'(pkt_src), PW'(3));
        tick();
        @(negedge clk);
        check("order_pkt3", PW'(pkt_src), PW'(4));
        tick();
        @(negedge clk);
        check("drained", PW'(pkt_valid), PW'(0));
        pkt_ready = 1'b0;
        tick();

        // tail of B on the same edge as pop of A
        send_flits(5, 0, 5);
        send_flits(6, 0, 4);
        pkt_ready = 1'b1;
        send(pf(6, 5), c);
        pkt_ready = 1'b0;
        valid_in  = 1'b0;
        @(negedge clk);
        check("coinc_valid", PW'(pkt_valid), PW'(1));
        check("coinc_src", PW'(pkt_src), PW'(6));
        check("coinc_tail", PW'(pkt_data[191:160]), PW'(32'hA000_0605));
        tick();
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;

        // valid_in gap mid-packet
        send_flits(7, 0, 2);
        valid_in = 1'b0;
        repeat (5) tick();
        send_flits(7, 3, 5);
        valid_in = 1'b0;
        @(negedge clk);
        check("gap_valid", PW'(pkt_valid), PW'(1));
        check("gap_flit2", PW'(pkt_data[95:64]), PW'(32'hA000_0702));
        check("gap_flit3", PW'(pkt_data[127:96]), PW'(32'hA000_0703));
        check("gap_flit5", PW'(pkt_data[191:160]), PW'(32'hA000_0705));
        tick();
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;

        // reset mid-packet with one packet still buffered
        send_flits(8, 0, 5);
        send_flits(9, 0, 3);
        valid_in = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", PW'(ready_in), PW'(0));
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("no_fragment", PW'(pkt_valid), PW'(0));
        tick();
        send_flits(10, 0, 5);
        valid_in = 1'b0;
        @(negedge clk);
        check("fresh_valid", PW'(pkt_valid), PW'(1));
        check("fresh_src", PW'(pkt_src), PW'(10));
        tick();
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;

`ifdef NOC_RX_DEST_CHECK_EN
        // misrouted packet: drained and counted, never presented
        send(32'h0000_0013, c);
        send_flits(3, 1, 5);
        valid_in = 1'b0;
        @(negedge clk);
        check("drop_valid", PW'(pkt_valid), PW'(0));
        check("drop_count_one", PW'(drop_count), PW'(1));
        tick();
        send_flits(2, 0, 5);
        valid_in = 1'b0;
        @(negedge clk);
        check("after_drop_valid", PW'(pkt_valid), PW'(1));
        check("after_drop_src", PW'(pkt_src), PW'(2));
        tick();
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
